// File: rtl/mixcol_if.sv
// Handshake bundle for the MixColumns sequencer: input state on one side,
// transformed state on the other.
interface mixcol_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mixcol_sequencer.sv
// Runs one shared MixColumns/InvMixColumns column unit over the four
// columns of a 128-bit AES state, one column per clock.
module mixcol_sequencer #(
    parameter int ENABLE_INV = 1
) (
    input  logic     clk,
    input  logic     rst,
    mixcol_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, nstate;
    logic [1:0] col;
    logic mode;
    logic [3:0][31:0] src;
    logic [3:0][31:0] res;
    logic [31:0] col_in, col_fwd, col_inv, col_out;
    logic accept, step;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column c sits at packed index 3-c, which is ~c for a 2-bit index.
    assign col_in = src[~col];

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col_in;

    assign col_fwd[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign col_fwd[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign col_fwd[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign col_fwd[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);

    generate
        if (ENABLE_INV != 0) begin : g_inv
            logic [7:0] b [4];
            logic [7:0] m9 [4];
            logic [7:0] m11 [4];
            logic [7:0] m13 [4];
            logic [7:0] m14 [4];
            always_comb begin
                b[0] = a0;
                b[1] = a1;
                b[2] = a2;
                b[3] = a3;
                for (int i = 0; i < 4; i++) begin
                    m9[i]  = xt(xt(xt(b[i]))) ^ b[i];
                    m11[i] = xt(xt(xt(b[i]))) ^ xt(b[i]) ^ b[i];
                    m13[i] = xt(xt(xt(b[i]))) ^ xt(xt(b[i])) ^ b[i];
                    m14[i] = xt(xt(xt(b[i]))) ^ xt(xt(b[i])) ^ xt(b[i]);
                end
            end
            assign col_inv[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
            assign col_inv[23:16] = m9[0] ^ m14[1] ^ m11[2] ^ m13[3];
            assign col_inv[15:8]  = m13[0] ^ m9[1] ^ m14[2] ^ m11[3];
            assign col_inv[7:0]   = m11[0] ^ m13[1] ^ m9[2] ^ m14[3];
        end else begin : g_noinv
            assign col_inv = col_fwd;
        end
    endgenerate

    assign col_out = mode ? col_inv : col_fwd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        accept = 1'b0;
        step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    nstate = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (col == 2'd3) nstate = DONE;
            end
            DONE: begin
                if (bus.out_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src  <= '0;
            res  <= '0;
            mode <= 1'b0;
            col  <= 2'd0;
        end else if (accept) begin
            src  <= bus.in_data;
            mode <= (ENABLE_INV != 0) ? bus.in_mode : 1'b0;
            col  <= 2'd0;
        end else if (step) begin
            res[~col] <= col_out;
            if (col != 2'd3) col <= col + 2'd1;
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = res;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mixcol_sequencer.sv
// Scoreboard bench for mixcol_sequencer: a GF(2^8) matrix model predicts each
// result, monitors compare whenever a result is retired.
module tb_mixcol_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mixcol_if ifa ();
    mixcol_if ifb ();

    mixcol_sequencer #(.ENABLE_INV(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mixcol_sequencer #(.ENABLE_INV(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_cmp = 0;
    int n_fail = 0;
    logic [127:0] qa [$];
    logic [127:0] qb [$];

    localparam logic [127:0] V_FIN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FOUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_BIN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V_BOUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V_ONES = {4{32'h01010101}};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix: row i uses coefficient cf[(j-i) mod 4] for byte j.
    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [7:0] cf [4];
        logic [127:0] r = '0;
        logic [7:0] acc;
        if (inv) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
        else     cf = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(d[127-8*(4*c+j) -: 8], cf[(j-i+4)%4]);
                r[127-8*(4*c+i) -: 8] = acc;
            end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_a: got %h expected none", ifa.out_data);
            end else chk("sb_a", ifa.out_data, qa.pop_front());
        end
        if (ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_b: got %h expected none", ifb.out_data);
            end else chk("sb_b", ifb.out_data, qb.pop_front());
        end
    end

    // Caller sits 1 ns after a rising edge; returns 1 ns after the accept edge.
    task automatic issue(input bit sel, input logic [127:0] d, input logic m);
        int k = 0;
        if (sel) begin ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_mode = m; end
        else     begin ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_mode = m; end
        while (!(sel ? ifb.in_ready : ifa.in_ready) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        if (sel) qb.push_back(model(d, 1'b0));
        else     qa.push_back(model(d, m));
        @(posedge clk); #1;
        if (sel) begin ifb.in_valid = 1'b0; ifb.in_data = {4{$urandom}}; end
        else     begin ifa.in_valid = 1'b0; ifa.in_data = {4{$urandom}}; end
    endtask

    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? ifb.out_valid : ifa.out_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire_rand(input bit sel);
        int k = 0;
        bit hs;
        do begin
            if (sel) ifb.out_ready = 1'($urandom_range(0, 1));
            else     ifa.out_ready = 1'($urandom_range(0, 1));
            hs = sel ? (ifb.out_valid && ifb.out_ready) : (ifa.out_valid && ifa.out_ready);
            @(posedge clk); #1;
            k++;
        end while (!hs && k < 60);
        if (!hs) begin
            n_cmp++;
            n_fail++;
            $display("FAIL retire_timeout: got no handshake expected one");
        end
        ifa.out_ready = 1'b0;
        ifb.out_ready = 1'b0;
    endtask

    task automatic retire_now();
        ifa.out_ready = 1'b1;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] held;
        logic [127:0] d;
        logic m;
        ifa.in_valid = 0; ifa.in_data = '0; ifa.in_mode = 0; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.in_data = '0; ifb.in_mode = 0; ifb.out_ready = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(ifa.in_ready), 128'(0));
        chk("rst_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("rst_out_data", ifa.out_data, 128'h0);
        chk("rst_busy", 128'(ifa.busy), 128'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 128'(ifa.in_ready), 128'(1));

        issue(0, V_FIN, 1'b0);
        wait_valid(0, lat);
        chk("fwd_latency", 128'(lat), 128'(4));
        chk("fwd_vec", ifa.out_data, V_FOUT);
        retire_now();

        issue(0, V_FOUT, 1'b1);
        wait_valid(0, lat);
        chk("inv_latency", 128'(lat), 128'(4));
        chk("inv_vec", ifa.out_data, V_FIN);
        retire_now();

        issue(0, V_BIN, 1'b0);
        wait_valid(0, lat);
        held = ifa.out_data;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 128'(ifa.out_valid), 128'(1));
            chk("bp_data", ifa.out_data, held);
            chk("bp_in_ready", 128'(ifa.in_ready), 128'(0));
            chk("bp_busy", 128'(ifa.busy), 128'(1));
            @(posedge clk); #1;
        end
        retire_now();
        chk("bp_exit_valid", 128'(ifa.out_valid), 128'(0));
        chk("bp_exit_data", ifa.out_data, V_BOUT);
        chk("bp_exit_in_ready", 128'(ifa.in_ready), 128'(1));

        issue(0, V_FIN, 1'b0);
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data = {$urandom, $urandom, $urandom, $urandom};
            ifa.in_mode = 1'($urandom_range(0, 1));
            chk("busy_in_ready", 128'(ifa.in_ready), 128'(0));
            @(posedge clk); #1;
        end
        issue(0, V_BIN, 1'b0);
        ifa.out_ready = 1'b0;
        wait_valid(0, lat);
        chk("second_vec", ifa.out_data, V_BOUT);
        retire_now();

        for (int n = 0; n < 16; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            issue(0, d, m);
            retire_rand(0);
        end

        issue(0, V_FIN, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(ifa.out_valid), 128'(0));
        chk("midrst_out_data", ifa.out_data, 128'h0);
        chk("midrst_busy", 128'(ifa.busy), 128'(0));
        qa.delete();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        issue(0, V_ONES, 1'b0);
        wait_valid(0, lat);
        chk("post_rst_latency", 128'(lat), 128'(4));
        chk("post_rst_vec", ifa.out_data, V_ONES);
        retire_now();

        issue(1, V_FIN, 1'b1);
        wait_valid(1, lat);
        chk("noinv_vec", ifb.out_data, V_FOUT);
        retire_rand(1);
        for (int n = 0; n < 6; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            issue(1, d, 1'($urandom_range(0, 1)));
            retire_rand(1);
        end

        repeat (2) @(posedge clk);
        chk("sb_a_drained", 128'(qa.size()), 128'(0));
        chk("sb_b_drained", 128'(qb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
